// File: rtl/iob_async_fifo_wr_ctrl.sv
// Write-side pointer controller of an asynchronous FIFO (write clock domain).
// Owns the Gray-coded write pointer, synchronises the read pointer through two
// flops and derives full / almost_full / level / sticky overflow from it.
// Read-side frees are seen three edges late, so full can be stale-high; writes
// refused during that window are flagged as overflow, which is the safe direction.
module iob_async_fifo_wr_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int ALMOST_FULL = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W:0]   r_gray_in,
    input  logic              clr_ovf,
    output logic              w_mem_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W:0]   w_gray_out,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH  = PTR_W'(1) << ADDR_W;
    localparam logic [PTR_W-1:0] AF_THR = PTR_W'(ALMOST_FULL);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_W-1:0] w_bin_q, w_bin_d;
    logic [PTR_W-1:0] w_gray_q, w_gray_d;
    logic [PTR_W-1:0] sync1_q, sync1_d;
    logic [PTR_W-1:0] sync2_q, sync2_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic             refuse;
    logic [PTR_W-1:0] r_bin;

    // Next-state logic: pointer advance, synchroniser shift, flag computation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        accept   = w_en & ~full_q;
        refuse   = w_en & full_q;
        r_bin    = gray2bin(sync2_q);

        w_bin_d  = w_bin_q + {{ADDR_W{1'b0}}, accept};
        w_gray_d = w_bin_d ^ (w_bin_d >> 1);

        sync1_d  = r_gray_in;
        sync2_d  = sync1_q;

        // Flags use the post-write pointer, so an accepted write shows at the same edge.
        level_d       = w_bin_d - r_bin;
        full_d        = (level_d == DEPTH);
        almost_full_d = (level_d >= AF_THR);

        // Set has priority over clear when both happen in one cycle.
        overflow_d = refuse | (overflow_q & ~clr_ovf);
    end

    // All write-domain state, asynchronously reset to the empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            w_bin_q       <= '0;
            w_gray_q      <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            w_bin_q       <= w_bin_d;
            w_gray_q      <= w_gray_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            level_q       <= level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign w_mem_en    = accept;
    assign w_addr      = w_bin_q[ADDR_W-1:0];
    assign w_gray_out  = w_gray_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign level       = level_q;
    assign overflow    = overflow_q;

endmodule
